fifo_rr_scheduler: RTL and testbench

- Round-robin dequeue scheduler that drains up to NUM_Q `FIFO` instances into one downstream consumer.
- Drives each FIFO's `deq` and captures its one-cycle `valid_out`/`data_out` response.
- Presents captured words on a valid/ready output tagged with the source queue index.
- Sits between the per-source FIFO bank and the single shared processing/stream stage.

---
 rtl/fifo_sched_pkg.sv | 17 +
 rtl/fifo_rr_scheduler_if.sv | 33 +++
 rtl/fifo_rr_scheduler_rr_arbiter.sv | 31 +++
 rtl/fifo_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO dequeue scheduler.
// Imported by the interface, the arbiter and the top.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    // Width of a queue index; kept at least 1 bit so a degenerate NUM_Q still elaborates.
    function automatic int src_w(input int num_q);
        return (num_q > 1) ? $clog2(num_q) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle between the FIFO bank, the scheduler and the downstream consumer.
// master = scheduler side, slave = FIFO bank / consumer side.
interface fifo_rr_scheduler_if
    import fifo_sched_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = src_w(NUM_Q);

    logic [NUM_Q-1:0]            q_empty_in;
    logic [NUM_Q-1:0]            q_valid_in;
    logic [NUM_Q*DATA_WIDTH-1:0] q_data_in;
    logic [NUM_Q-1:0]            q_deq_out;
    logic [NUM_Q-1:0]            q_enable_in;
    logic [DATA_WIDTH-1:0]       m_data_out;
    logic [SRC_W-1:0]            m_src_out;
    logic                        m_valid_out;
    logic                        m_ready_in;
    logic                        busy_out;
    logic                        underrun_err_out;

    modport master (
        input  q_empty_in, q_valid_in, q_data_in, q_enable_in, m_ready_in,
        output q_deq_out, m_data_out, m_src_out, m_valid_out, busy_out, underrun_err_out
    );

    modport slave (
        output q_empty_in, q_valid_in, q_data_in, q_enable_in, m_ready_in,
        input  q_deq_out, m_data_out, m_src_out, m_valid_out, busy_out, underrun_err_out
    );

endinterface

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester after i_last, with wrap.
// Stateless so it can also serve multi-master enqueue arbitration.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int  NUM_Q = 4,
    localparam int SRC_W = src_w(NUM_Q)
) (
    input  logic [NUM_Q-1:0] i_req,
    input  logic [SRC_W-1:0] i_last,
    output logic             o_gnt_valid,
    output logic [SRC_W-1:0] o_gnt_idx
);

    logic [SRC_W-1:0] w_idx;

    // Scan farthest-to-nearest so the nearest requester after i_last is the last writer.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_idx       = '0;
        for (int k = NUM_Q; k >= 1; k--) begin
            w_idx = SRC_W'((int'(i_last) + k) % NUM_Q);
            if (i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin dequeue scheduler: pops one FIFO at a time, captures its
// one-cycle response and presents it on a valid/ready port tagged with the source.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; grant when any enabled FIFO is non-empty
// ST_ISSUE | q_deq_out[sel] high for this single cycle
// ST_WAIT  | FIFO responds; capture word or flag underrun
// ST_HOLD  | word presented; wait for m_ready_in, may chain next grant
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    fifo_rr_scheduler_if.master bus
);

    localparam int SRC_W = src_w(NUM_Q);

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    logic [SRC_W-1:0]      r_sel;
    logic [SRC_W-1:0]      r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SRC_W-1:0]      r_src;
    logic                  r_valid;
    logic                  r_underrun;

    logic [NUM_Q-1:0]      w_elig;
    logic                  w_gnt_valid;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_Q-1:0]      w_deq;
    logic                  w_load_grant;
    logic                  w_capture;
    logic                  w_underrun;
    logic                  w_release;

    assign w_elig = ~bus.q_empty_in & bus.q_enable_in;

    rr_arbiter #(
        .NUM_Q (NUM_Q)
    ) u_rr_arbiter (
        .i_req       (w_elig),
        .i_last      (r_last),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_sel_valid = bus.q_valid_in[r_sel];

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (r_sel == SRC_W'(i)) begin
                w_sel_data = bus.q_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        w_capture    = 1'b0;
        w_underrun   = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_load_grant = 1'b1;
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_sel_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_underrun  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.m_ready_in) begin
                    w_release = 1'b1;
                    if (w_gnt_valid) begin
                        w_load_grant = 1'b1;
                        w_state_nxt  = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset drops any word that was dequeued but not yet captured.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_last     <= SRC_W'(NUM_Q - 1);
            r_data     <= '0;
            r_src      <= '0;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_underrun <= w_underrun;
            if (w_load_grant) begin
                r_sel  <= w_gnt_idx;
                r_last <= w_gnt_idx;
            end
            if (w_capture) begin
                r_data  <= w_sel_data;
                r_src   <= r_sel;
                r_valid <= 1'b1;
            end else if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_deq = '0;
        if (r_state == ST_ISSUE) begin
            w_deq[r_sel] = 1'b1;
        end
    end

    assign bus.q_deq_out        = w_deq;
    assign bus.m_data_out       = r_data;
    assign bus.m_src_out        = r_src;
    assign bus.m_valid_out      = r_valid;
    assign bus.busy_out         = (r_state != ST_IDLE);
    assign bus.underrun_err_out = r_underrun;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with a behavioural 4-FIFO bank.
// FIFO word n of queue q reads 0xA5A5_nnqq.
module tb_fifo_rr_scheduler;

    localparam int NQ = 4;
    localparam int DW = 32;

    logic clk_sys = 1'b0;
    logic rst_b;

    always #5 clk_sys = ~clk_sys;

    fifo_rr_scheduler_if #(.NUM_Q(NQ), .DATA_WIDTH(DW)) bus ();

    fifo_rr_scheduler #(
        .NUM_Q      (NQ),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk_in   (clk_sys),
        .rst_n_in (rst_b),
        .bus      (bus)
    );

    int n_cmp     = 0;
    int n_err     = 0;
    int n_multi   = 0;
    int n_overrun = 0;

    int          fill   [NQ];
    int          popped [NQ];
    logic [NQ-1:0] fv;
    logic [NQ-1:0] supp;
    logic [DW-1:0] fd   [NQ];
    logic [NQ-1:0]    w_empty;
    logic [NQ*DW-1:0] w_qdata;

    int          got_src  [16];
    logic [DW-1:0] got_data [16];
    int          got_cyc  [16];
    int          mask_q   [8] = '{1, 3, 1, 3, 0, 2, 0, 2};
    int          mask_n   [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    function automatic logic [31:0] word(input int q, input int n);
        return 32'hA5A5_0000 | (32'(n) << 8) | 32'(q);
    endfunction

    always_comb begin
        w_empty = '0;
        w_qdata = '0;
        for (int i = 0; i < NQ; i++) begin
            w_empty[i]            = (fill[i] <= popped[i]);
            w_qdata[i*DW +: DW]   = fd[i];
        end
    end

    assign bus.q_empty_in = w_empty;
    assign bus.q_data_in  = w_qdata;
    assign bus.q_valid_in = fv;

    // FIFO bank: deq pops at the edge, valid_out/data_out follow for one cycle.
    always @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            fv <= '0;
            for (int i = 0; i < NQ; i++) begin
                popped[i] <= 0;
                fd[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NQ; i++) begin
                fv[i] <= bus.q_deq_out[i] & ~supp[i];
                if (bus.q_deq_out[i]) begin
                    fd[i]     <= word(i, popped[i]);
                    popped[i] <= popped[i] + 1;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (rst_b) begin
            if ($countones(bus.q_deq_out) > 1) n_multi++;
            if ((bus.q_deq_out != '0) && bus.m_valid_out) n_overrun++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        for (int i = 0; i < NQ; i++) fill[i] = 0;
        supp            = '0;
        bus.q_enable_in = '1;
        bus.m_ready_in  = 1'b1;
        tick();
        tick();
        @(negedge clk_sys);
        rst_b = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (!bus.m_valid_out && c < max_cyc) begin
            tick();
            c++;
        end
        check_eq({tag, "_seen"}, 64'(bus.m_valid_out), 64'd1);
    endtask

    task automatic collect(input int nwords, input int max_cyc, input int switch_at, output int n);
        n = 0;
        for (int c = 0; c < max_cyc && n < nwords; c++) begin
            tick();
            if (bus.m_valid_out) begin
                got_src[n]  = int'(bus.m_src_out);
                got_data[n] = bus.m_data_out;
                got_cyc[n]  = c;
                n++;
                if (n == switch_at) bus.q_enable_in = '1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int n;

        // reset values
        rst_b = 1'b0;
        for (int i = 0; i < NQ; i++) fill[i] = 0;
        supp            = '0;
        bus.q_enable_in = '1;
        bus.m_ready_in  = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", 64'(bus.m_valid_out), 64'd0);
        check_eq("rst_deq", 64'(bus.q_deq_out), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_out), 64'd0);
        check_eq("rst_unr", 64'(bus.underrun_err_out), 64'd0);
        check_eq("rst_src", 64'(bus.m_src_out), 64'd0);
        check_eq("rst_data", 64'(bus.m_data_out), 64'd0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        tick();
        check_eq("idle_busy", 64'(bus.busy_out), 64'd0);

        // single source: only q2
        do_reset();
        fill[2] = 1;
        tick();
        check_eq("ss_deq", 64'(bus.q_deq_out), 64'b0100);
        check_eq("ss_busy", 64'(bus.busy_out), 64'd1);
        tick();
        check_eq("ss_deq_off", 64'(bus.q_deq_out), 64'd0);
        check_eq("ss_valid_early", 64'(bus.m_valid_out), 64'd0);
        tick();
        check_eq("ss_valid", 64'(bus.m_valid_out), 64'd1);
        check_eq("ss_data", 64'(bus.m_data_out), 64'hA5A5_0002);
        check_eq("ss_src", 64'(bus.m_src_out), 64'd2);
        tick();
        check_eq("ss_valid_clr", 64'(bus.m_valid_out), 64'd0);
        check_eq("ss_idle", 64'(bus.busy_out), 64'd0);

        // fairness: 3 words in every FIFO
        do_reset();
        for (int i = 0; i < NQ; i++) fill[i] = 3;
        collect(12, 60, -1, n);
        check_eq("fair_count", 64'(n), 64'd12);
        for (int k = 0; k < 12; k++) begin
            check_eq($sformatf("fair_src%0d", k), 64'(got_src[k]), 64'(k % 4));
            check_eq($sformatf("fair_data%0d", k), 64'(got_data[k]), 64'(word(k % 4, k / 4)));
            if (k > 0) check_eq($sformatf("fair_gap%0d", k), 64'(got_cyc[k] - got_cyc[k-1]), 64'd3);
        end
        tick();
        for (int i = 0; i < NQ; i++) check_eq($sformatf("fair_pops%0d", i), 64'(popped[i]), 64'd3);

        // backpressure while holding
        do_reset();
        bus.m_ready_in = 1'b0;
        fill[0] = 2;
        fill[1] = 1;
        wait_valid("bp", 10);
        check_eq("bp_src", 64'(bus.m_src_out), 64'd0);
        check_eq("bp_data", 64'(bus.m_data_out), 64'hA5A5_0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("bp_valid%0d", c), 64'(bus.m_valid_out), 64'd1);
            check_eq($sformatf("bp_hold%0d", c), {bus.m_data_out, 30'd0, bus.m_src_out}, {32'hA5A5_0000, 32'd0});
            check_eq($sformatf("bp_nodeq%0d", c), 64'(bus.q_deq_out), 64'd0);
        end
        bus.m_ready_in = 1'b1;
        tick();
        check_eq("bp_issue", 64'(bus.q_deq_out), 64'b0010);
        check_eq("bp_valid_clr", 64'(bus.m_valid_out), 64'd0);
        tick();
        tick();
        check_eq("bp_w2_src", 64'(bus.m_src_out), 64'd1);
        check_eq("bp_w2_data", 64'(bus.m_data_out), 64'hA5A5_0001);
        tick();
        check_eq("bp_w3_issue", 64'(bus.q_deq_out), 64'b0001);
        tick();
        tick();
        check_eq("bp_w3_data", 64'(bus.m_data_out), 64'hA5A5_0100);

        // service mask, widened mid-HOLD after the 4th word
        do_reset();
        bus.q_enable_in = 4'b1010;
        for (int i = 0; i < NQ; i++) fill[i] = 2;
        collect(8, 60, 4, n);
        check_eq("mask_count", 64'(n), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("mask_src%0d", k), 64'(got_src[k]), 64'(mask_q[k]));
            check_eq($sformatf("mask_data%0d", k), 64'(got_data[k]), 64'(word(mask_q[k], mask_n[k])));
        end

        // underrun: q0 never answers, q1 served next
        do_reset();
        supp    = 4'b0001;
        fill[0] = 1;
        fill[1] = 1;
        tick();
        check_eq("unr_deq0", 64'(bus.q_deq_out), 64'b0001);
        tick();
        check_eq("unr_early", 64'(bus.underrun_err_out), 64'd0);
        tick();
        check_eq("unr_pulse", 64'(bus.underrun_err_out), 64'd1);
        check_eq("unr_novalid", 64'(bus.m_valid_out), 64'd0);
        check_eq("unr_idle", 64'(bus.busy_out), 64'd0);
        tick();
        check_eq("unr_pulse_end", 64'(bus.underrun_err_out), 64'd0);
        check_eq("unr_deq1", 64'(bus.q_deq_out), 64'b0010);
        tick();
        tick();
        check_eq("unr_valid", 64'(bus.m_valid_out), 64'd1);
        check_eq("unr_src", 64'(bus.m_src_out), 64'd1);
        check_eq("unr_data", 64'(bus.m_data_out), 64'hA5A5_0001);
        supp = '0;

        // asynchronous reset mid-HOLD
        do_reset();
        bus.m_ready_in = 1'b0;
        fill[1] = 1;
        wait_valid("ar", 10);
        #3;
        rst_b = 1'b0;
        for (int i = 0; i < NQ; i++) fill[i] = 0;
        #1;
        check_eq("ar_valid", 64'(bus.m_valid_out), 64'd0);
        check_eq("ar_deq", 64'(bus.q_deq_out), 64'd0);
        check_eq("ar_busy", 64'(bus.busy_out), 64'd0);
        check_eq("ar_unr", 64'(bus.underrun_err_out), 64'd0);
        check_eq("ar_data", 64'(bus.m_data_out), 64'd0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        rst_b = 1'b1;
        tick();
        bus.m_ready_in = 1'b1;
        fill[0] = 1;
        fill[1] = 1;
        wait_valid("ar_first", 10);
        check_eq("ar_first_src", 64'(bus.m_src_out), 64'd0);
        check_eq("ar_first_data", 64'(bus.m_data_out), 64'hA5A5_0000);
        tick();
        tick();

        check_eq("multi_deq", 64'(n_multi), 64'd0);
        check_eq("deq_in_hold", 64'(n_overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
